// File: rtl/gearbox_n_to_m.sv
// rtl/gearbox_n_to_m.sv - IN_W to OUT_W bit gearbox with pulsed bit-slip
// Define GBX_AUTO_ALIGN_EN to build the training-pattern auto-align FSM.
module gearbox_n_to_m #(
   parameter int               IN_W          = 6,
   parameter int               OUT_W         = 12,
   parameter logic [OUT_W-1:0] TRAIN_PATTERN = OUT_W'(12'hF00),
   parameter int               LOCK_CNT      = 16,
   parameter int               SETTLE        = 4
) (
   input  logic                     px_clk,
   input  logic                     px_reset_n,
   input  logic [IN_W-1:0]          din,
   input  logic                     din_valid,
   input  logic                     bitslip,
   input  logic                     align_en,
   output logic [OUT_W-1:0]         dout,
   output logic                     dout_valid,
   output logic [$clog2(OUT_W)-1:0] slip_cnt,
   output logic                     aligned
);
   localparam int AW = OUT_W + IN_W - 1;
   localparam int CW = $clog2(OUT_W + IN_W);
   localparam int SW = $clog2(OUT_W);

   logic [AW-1:0]    acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [OUT_W-1:0] dout_q, dout_d;
   logic             dout_valid_q, dout_valid_d;
   logic [SW-1:0]    slip_cnt_q, slip_cnt_d;
   logic             slip_pend_q, slip_pend_d;
   logic             slip_req, do_slip, do_emit, auto_slip;

`ifdef GBX_AUTO_ALIGN_EN
   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam int KW = $clog2(SETTLE + 1);
   typedef enum logic [1:0] {ST_SEARCH, ST_SETTLE, ST_LOCKED} state_t;

   state_t        state_q;
   logic [MW-1:0] match_q;
   logic [KW-1:0] skip_q;
   logic          auto_slip_q, aligned_q;

   always_ff @(posedge px_clk or negedge px_reset_n) begin
      if (!px_reset_n) begin
         state_q     <= ST_SEARCH;
         match_q     <= '0;
         skip_q      <= '0;
         auto_slip_q <= 1'b0;
         aligned_q   <= 1'b0;
      end else begin
         auto_slip_q <= 1'b0;
         if (!align_en) begin
            state_q   <= ST_SEARCH;
            match_q   <= '0;
            skip_q    <= '0;
            aligned_q <= 1'b0;
         end else if (dout_valid_q) begin
            case (state_q)
               ST_SEARCH: begin
                  if (dout_q == TRAIN_PATTERN) begin
                     match_q <= match_q + MW'(1);
                     if (match_q == MW'(LOCK_CNT - 1)) begin
                        state_q   <= ST_LOCKED;
                        aligned_q <= 1'b1;
                     end
                  end else begin
                     match_q     <= '0;
                     skip_q      <= '0;
                     auto_slip_q <= 1'b1;
                     state_q     <= ST_SETTLE;
                  end
               end
               // Words seen here may predate the slip, so they are never judged.
               ST_SETTLE: begin
                  if (skip_q == KW'(SETTLE - 1)) state_q <= ST_SEARCH;
                  else                           skip_q  <= skip_q + KW'(1);
               end
               default: ;
            endcase
         end
      end
   end

   assign auto_slip = auto_slip_q;
   assign aligned   = aligned_q;
`else
   logic unused_cfg;
   assign unused_cfg = align_en ^ (^TRAIN_PATTERN) ^ (LOCK_CNT > 0) ^ (SETTLE > 0);
   assign auto_slip  = 1'b0;
   assign aligned    = 1'b0;
`endif

   always_comb begin
      slip_req = bitslip | auto_slip;
      // A slip is deferred by one cycle when taking it alongside new input would overflow acc.
      do_slip = slip_pend_q && (cnt_q != '0) && !(din_valid && (cnt_q > CW'(OUT_W)));
      do_emit = !do_slip && (cnt_q >= CW'(OUT_W));
      acc_d        = din_valid ? AW'({acc_q, din}) : acc_q;
      cnt_d        = cnt_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      slip_cnt_d   = slip_cnt_q;
      slip_pend_d  = slip_pend_q;
      if (do_slip) begin
         cnt_d       = cnt_q - CW'(1);
         slip_pend_d = 1'b0;
         slip_cnt_d  = (slip_cnt_q == SW'(OUT_W - 1)) ? '0 : slip_cnt_q + SW'(1);
      end else if (do_emit) begin
         cnt_d        = cnt_q - CW'(OUT_W);
         dout_d       = OUT_W'(acc_q >> (cnt_q - CW'(OUT_W)));
         dout_valid_d = 1'b1;
      end
      if (din_valid) cnt_d = cnt_d + CW'(IN_W);
      if (!slip_pend_q && slip_req) slip_pend_d = 1'b1;
   end

   always_ff @(posedge px_clk or negedge px_reset_n) begin
      if (!px_reset_n) begin
         acc_q        <= '0;
         cnt_q        <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         slip_cnt_q   <= '0;
         slip_pend_q  <= 1'b0;
      end else begin
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         slip_cnt_q   <= slip_cnt_d;
         slip_pend_q  <= slip_pend_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign slip_cnt   = slip_cnt_q;
endmodule
